// File: rtl/uart_led_cmd_parser.sv
// uart_led_cmd_parser: parses "L" + 8 hex digits + CR/LF from the UART RX FIFO into LED register writes,
// acking each complete or failed frame with 'K' or 'E' on the UART TX port.
module uart_led_cmd_parser #(
    parameter int NUM_LEDS       = 16,
    parameter int TIMEOUT_CYCLES = 8000000
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic        i_Received,
    output logic        o_Read_FIFO,
    input  logic [7:0]  i_Data,
    input  logic        i_Data_Ready,
    output logic        o_TX_Start,
    output logic [7:0]  o_TX_Data,
    input  logic        i_TX_Busy,
    output logic        o_LED_Wr,
    output logic [7:0]  o_LED_Addr,
    output logic [23:0] o_LED_RGB,
    output logic [7:0]  o_Err_Count
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, PARSE, EXEC, ACK} state_t;
    state_t          state, state_nxt;
    logic            first, pending, is_l, is_term, is_dig, is_hex, perr, idx_ok, err_inc;
    logic [7:0]      rx_byte, ack_byte;
    logic [3:0]      cnt, nib;
    logic [31:0]     sr;
    logic [TW-1:0]   timer;

    assign is_l    = rx_byte == 8'h4C || rx_byte == 8'h6C;
    assign is_term = rx_byte == 8'h0D || rx_byte == 8'h0A;
    assign is_dig  = rx_byte >= 8'h30 && rx_byte <= 8'h39;
    assign is_hex  = is_dig || (rx_byte >= 8'h41 && rx_byte <= 8'h46) || (rx_byte >= 8'h61 && rx_byte <= 8'h66);
    assign nib     = is_dig ? rx_byte[3:0] : rx_byte[3:0] + 4'd9;
    assign perr    = !is_l && cnt != 4'd0 && (cnt == 4'd9 ? !is_term : !is_hex);
    assign idx_ok  = {1'b0, sr[31:24]} < 9'(NUM_LEDS);
    assign err_inc = (state == PARSE && perr) || (state == EXEC && !idx_ok);

    always_ff @(posedge i_Clock or posedge i_Reset)
        if (i_Reset) state <= IDLE;
        else         state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = (pending && !i_TX_Busy) ? ACK : (!pending && i_Received) ? REQ : IDLE;
            REQ:     state_nxt = WAIT;
            WAIT:    state_nxt = (!first && i_Data_Ready) ? PARSE : WAIT;
            PARSE:   state_nxt = (!is_l && cnt == 4'd9 && is_term) ? EXEC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_Read_FIFO = state == REQ;
        o_TX_Start  = state == ACK;
        o_TX_Data   = o_TX_Start ? ack_byte : 8'h00;
        o_LED_Wr    = state == EXEC && idx_ok;
    end

    // The UART holds i_Data_Ready low only from the cycle after REQ, so the first WAIT cycle is skipped.
    always_ff @(posedge i_Clock or posedge i_Reset)
        if (i_Reset) begin
            first       <= 1'b0;
            pending     <= 1'b0;
            rx_byte     <= 8'h00;
            ack_byte    <= 8'h00;
            cnt         <= 4'd0;
            sr          <= 32'h0;
            timer       <= '0;
            o_LED_Addr  <= 8'h00;
            o_LED_RGB   <= 24'h0;
            o_Err_Count <= 8'h00;
        end else begin
            first <= state == REQ;
            if (state == WAIT && !first && i_Data_Ready) rx_byte <= i_Data;
            if (state == PARSE || cnt == 4'd0) timer <= '0;
            else if (timer == TW'(TIMEOUT_CYCLES)) begin
                timer <= '0;
                cnt   <= 4'd0;
            end else timer <= timer + 1'b1;
            if (err_inc && o_Err_Count != 8'hFF) o_Err_Count <= o_Err_Count + 8'd1;
            if (state == PARSE) begin
                if (is_l) cnt <= 4'd1;
                else if (perr) begin
                    cnt      <= 4'd0;
                    ack_byte <= 8'h45;
                    pending  <= 1'b1;
                end else if (cnt != 4'd0 && cnt != 4'd9) begin
                    sr  <= {sr[27:0], nib};
                    cnt <= cnt + 4'd1;
                end else if (cnt == 4'd9 && idx_ok) begin
                    o_LED_Addr <= sr[31:24];
                    o_LED_RGB  <= sr[23:0];
                end
            end
            if (state == EXEC) begin
                ack_byte <= idx_ok ? 8'h4B : 8'h45;
                pending  <= 1'b1;
                cnt      <= 4'd0;
            end
            if (state == ACK) pending <= 1'b0;
        end
endmodule

// File: tb/tb_uart_led_cmd_parser.sv
// tb_uart_led_cmd_parser: directed frames against a small UART FIFO/TX model; checks LED writes, acks and error count.
module tb_uart_led_cmd_parser;
    localparam int TO = 40;
    logic        i_Clock = 1'b0, i_Reset = 1'b1, i_Received = 1'b0, i_Data_Ready = 1'b1, i_TX_Busy = 1'b0;
    logic [7:0]  i_Data = 8'h00;
    logic        o_Read_FIFO, o_TX_Start, o_LED_Wr;
    logic [7:0]  o_TX_Data, o_LED_Addr, o_Err_Count;
    logic [23:0] o_LED_RGB;
    logic [7:0]  q[$];
    logic [7:0]  acks[$];
    logic [1:0]  dly = 2'd0;
    int          checks = 0, failures = 0, wr_cnt = 0, rd_cnt = 0, w0, r0;
    logic [7:0]  wr_addr = 8'h00;
    logic [23:0] wr_rgb = 24'h0;

    uart_led_cmd_parser #(.NUM_LEDS(16), .TIMEOUT_CYCLES(TO)) dut (
        .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Received(i_Received), .o_Read_FIFO(o_Read_FIFO),
        .i_Data(i_Data), .i_Data_Ready(i_Data_Ready), .o_TX_Start(o_TX_Start), .o_TX_Data(o_TX_Data),
        .i_TX_Busy(i_TX_Busy), .o_LED_Wr(o_LED_Wr), .o_LED_Addr(o_LED_Addr), .o_LED_RGB(o_LED_RGB),
        .o_Err_Count(o_Err_Count));

    always #5 i_Clock = ~i_Clock;

    // RX FIFO read port: data valid two edges after the request, with Data_Ready low meanwhile
    always @(posedge i_Clock)
        if (i_Reset) begin
            i_Data_Ready <= 1'b1;
            dly          <= 2'd0;
            i_Received   <= 1'b0;
        end else begin
            if (o_Read_FIFO) begin
                i_Data_Ready <= 1'b0;
                dly          <= 2'd2;
                if (q.size() != 0) i_Data <= q.pop_front();
            end else if (dly != 2'd0) begin
                dly <= dly - 2'd1;
                if (dly == 2'd1) i_Data_Ready <= 1'b1;
            end
            i_Received <= q.size() != 0;
        end

    always @(negedge i_Clock) begin
        if (o_LED_Wr) begin
            wr_cnt++;
            wr_addr = o_LED_Addr;
            wr_rgb  = o_LED_RGB;
        end
        if (o_TX_Start) acks.push_back(o_TX_Data);
        if (o_Read_FIFO) rd_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input string s);
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    endtask

    task automatic run_acks(input string tag, input int n, input int budget);
        int k = 0;
        while (acks.size() < n && k < budget) begin
            @(negedge i_Clock);
            k++;
        end
        repeat (30) @(negedge i_Clock);
        chk(tag, acks.size(), n);
    endtask

    task automatic drain(input int extra);
        int k = 0;
        while (q.size() != 0 && k < 5000) begin
            @(negedge i_Clock);
            k++;
        end
        repeat (extra) @(negedge i_Clock);
    endtask

    initial begin
        repeat (3) @(negedge i_Clock);
        chk("rst_read", o_Read_FIFO, 0);
        chk("rst_txs", o_TX_Start, 0);
        chk("rst_txd", o_TX_Data, 0);
        chk("rst_wr", o_LED_Wr, 0);
        chk("rst_addr", o_LED_Addr, 0);
        chk("rst_rgb", o_LED_RGB, 0);
        chk("rst_err", o_Err_Count, 0);
        i_Reset = 1'b0;

        send("L0AFF8000\r");
        run_acks("t1_acks", 1, 500);
        chk("t1_wr", wr_cnt, 1);
        chk("t1_addr", wr_addr, 8'h0A);
        chk("t1_rgb", wr_rgb, 24'hFF8000);
        chk("t1_ack", acks[0], 8'h4B);
        chk("t1_hold", o_LED_RGB, 24'hFF8000);
        acks.delete();

        send("L20123456\n");
        run_acks("t2_acks", 1, 500);
        chk("t2_wr", wr_cnt, 1);
        chk("t2_ack", acks[0], 8'h45);
        chk("t2_err", o_Err_Count, 1);
        chk("t2_hold", o_LED_Addr, 8'h0A);
        acks.delete();

        send("xyL01abcdef\r");
        run_acks("t3_acks", 1, 500);
        chk("t3_wr", wr_cnt, 2);
        chk("t3_addr", wr_addr, 8'h01);
        chk("t3_rgb", wr_rgb, 24'hABCDEF);
        chk("t3_ack", acks[0], 8'h4B);
        acks.delete();

        send("L01G");
        run_acks("t4_acks", 1, 500);
        chk("t4_ack", acks[0], 8'h45);
        chk("t4_err", o_Err_Count, 2);
        acks.delete();
        send("L0200FF00\r");
        run_acks("t4b_acks", 1, 500);
        chk("t4b_addr", wr_addr, 8'h02);
        chk("t4b_rgb", wr_rgb, 24'h00FF00);
        chk("t4b_ack", acks[0], 8'h4B);
        acks.delete();

        w0 = wr_cnt;
        send("L01AB");
        drain(TO + 20);
        chk("t5_noack", acks.size(), 0);
        send("0000FF\r");
        drain(100);
        chk("t5_noack2", acks.size(), 0);
        chk("t5_nowr", wr_cnt, w0);

        send("l0F000001\r\n");
        run_acks("t6_acks", 1, 500);
        drain(50);
        chk("t6_one", acks.size(), 1);
        chk("t6_addr", wr_addr, 8'h0F);
        chk("t6_rgb", wr_rgb, 24'h000001);
        chk("t6_err", o_Err_Count, 2);
        acks.delete();

        i_TX_Busy = 1'b1;
        r0 = rd_cnt;
        send("L0100000A\r");
        send("L10000000\r");
        send("L0300000C\r");
        repeat (200) @(negedge i_Clock);
        chk("t7_stall_acks", acks.size(), 0);
        chk("t7_stall_reads", rd_cnt - r0, 10);
        chk("t7_backlog", q.size(), 20);
        i_TX_Busy = 1'b0;
        run_acks("t7_acks", 3, 1000);
        chk("t7_ack0", acks[0], 8'h4B);
        chk("t7_ack1", acks[1], 8'h45);
        chk("t7_ack2", acks[2], 8'h4B);
        chk("t7_addr", wr_addr, 8'h03);
        chk("t7_err", o_Err_Count, 3);
        acks.delete();

        for (int i = 0; i < 256; i++) send("LG");
        run_acks("t8_acks", 256, 10000);
        chk("t8_sat", o_Err_Count, 8'hFF);
        acks.delete();

        send("L05");
        repeat (8) @(negedge i_Clock);
        i_Reset = 1'b1;
        q.delete();
        @(negedge i_Clock);
        chk("t9_err", o_Err_Count, 0);
        chk("t9_addr", o_LED_Addr, 0);
        chk("t9_read", o_Read_FIFO, 0);
        i_Reset = 1'b0;
        repeat (20) @(negedge i_Clock);
        chk("t9_noack", acks.size(), 0);
        send("L0E123456\r");
        run_acks("t9_acks", 1, 500);
        chk("t9_ack", acks[0], 8'h4B);
        chk("t9_waddr", wr_addr, 8'h0E);
        chk("t9_wrgb", wr_rgb, 24'h123456);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
